// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
//   Router input port: accepts link flits tagged with a VC id into four
//   per-VC FIFOs, pops the VC chosen by the output arbiter with one cycle of
//   latency, returns one credit per popped flit, and checks head/body/tail
//   framing per VC.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid/in_vc/in_flit    incoming link flit and its target VC
//   rd_en/rd_vc               pop request from the arbiter and VC to pop
//   not_empty_0..3, full_0..3 per-VC occupancy flags (from registered counts)
//   out_valid/out_flit/out_vc popped flit, registered
//   credit_valid/credit_vc    one-cycle credit return pulse
//   overflow_err              sticky: write to a full VC was dropped
//   protocol_err              sticky: framing violation seen
// -----------------------------------------------------------------------------
module vc_input_buffer #(
   parameter int unsigned FLIT_W = 34,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned NUM_VC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [1:0]        in_vc,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              rd_en,
   input  logic [1:0]        rd_vc,
   output logic              not_empty_0,
   output logic              not_empty_1,
   output logic              not_empty_2,
   output logic              not_empty_3,
   output logic              full_0,
   output logic              full_1,
   output logic              full_2,
   output logic              full_3,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   output logic [1:0]        out_vc,
   output logic              credit_valid,
   output logic [1:0]        credit_vc,
   output logic              overflow_err,
   output logic              protocol_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic {FR_IDLE, FR_ACTIVE} frame_st_t;

   logic [FLIT_W-1:0] mem_q     [NUM_VC][DEPTH];
   logic [FLIT_W-1:0] mem_d     [NUM_VC][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q  [NUM_VC];
   logic [PTR_W-1:0]  wr_ptr_d  [NUM_VC];
   logic [PTR_W-1:0]  rd_ptr_q  [NUM_VC];
   logic [PTR_W-1:0]  rd_ptr_d  [NUM_VC];
   logic [CNT_W-1:0]  count_q   [NUM_VC];
   logic [CNT_W-1:0]  count_d   [NUM_VC];
   frame_st_t         frame_q   [NUM_VC];
   frame_st_t         frame_d   [NUM_VC];

   logic              out_valid_q, out_valid_d;
   logic [FLIT_W-1:0] out_flit_q,  out_flit_d;
   logic [1:0]        out_vc_q,    out_vc_d;
   logic              credit_valid_q, credit_valid_d;
   logic [1:0]        credit_vc_q, credit_vc_d;
   logic              overflow_q,  overflow_d;
   logic              protocol_q,  protocol_d;

   logic              pop_acc;
   logic              wr_acc;
   logic [1:0]        ftype;

   always_comb begin
      mem_d          = mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      frame_d        = frame_q;
      out_flit_d     = out_flit_q;
      out_vc_d       = out_vc_q;
      credit_vc_d    = credit_vc_q;
      overflow_d     = overflow_q;
      protocol_d     = protocol_q;
      ftype          = in_flit[FLIT_W-1 -: 2];

      pop_acc        = rd_en && (count_q[rd_vc] != '0);
      // A full VC still accepts a write when the same VC is popped this cycle
      wr_acc         = in_valid && ((count_q[in_vc] != CNT_FULL) ||
                                    (pop_acc && (rd_vc == in_vc)));
      out_valid_d    = pop_acc;
      credit_valid_d = pop_acc;

      // Read uses pre-edge storage, so a same-cycle write to the slot being
      // popped (full VC, wr_ptr == rd_ptr) cannot corrupt the output.
      if (pop_acc) begin
         out_flit_d      = mem_q[rd_vc][rd_ptr_q[rd_vc]];
         out_vc_d        = rd_vc;
         credit_vc_d     = rd_vc;
         rd_ptr_d[rd_vc] = rd_ptr_q[rd_vc] + PTR_ONE;
      end

      if (wr_acc) begin
         mem_d[in_vc][wr_ptr_q[in_vc]] = in_flit;
         wr_ptr_d[in_vc]               = wr_ptr_q[in_vc] + PTR_ONE;
      end

      if (in_valid && !wr_acc) begin
         overflow_d = 1'b1;
      end

      for (int unsigned v = 0; v < NUM_VC; v++) begin
         if ((wr_acc && (in_vc == 2'(v))) && !(pop_acc && (rd_vc == 2'(v)))) begin
            count_d[v] = count_q[v] + CNT_ONE;
         end else if (!(wr_acc && (in_vc == 2'(v))) && (pop_acc && (rd_vc == 2'(v)))) begin
            count_d[v] = count_q[v] - CNT_ONE;
         end
      end

      if (wr_acc) begin
         case (frame_q[in_vc])
            FR_IDLE: begin
               case (ftype)
                  2'b01:   frame_d[in_vc] = FR_ACTIVE;
                  2'b11:   frame_d[in_vc] = FR_IDLE;
                  default: protocol_d     = 1'b1;
               endcase
            end
            default: begin
               // A stray head restarts framing from the new flit
               case (ftype)
                  2'b00:   frame_d[in_vc] = FR_ACTIVE;
                  2'b10:   frame_d[in_vc] = FR_IDLE;
                  2'b01: begin
                     protocol_d     = 1'b1;
                     frame_d[in_vc] = FR_ACTIVE;
                  end
                  default: begin
                     protocol_d     = 1'b1;
                     frame_d[in_vc] = FR_IDLE;
                  end
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
            frame_q[v]  <= FR_IDLE;
         end
         out_valid_q    <= 1'b0;
         out_flit_q     <= '0;
         out_vc_q       <= '0;
         credit_valid_q <= 1'b0;
         credit_vc_q    <= '0;
         overflow_q     <= 1'b0;
         protocol_q     <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         frame_q        <= frame_d;
         out_valid_q    <= out_valid_d;
         out_flit_q     <= out_flit_d;
         out_vc_q       <= out_vc_d;
         credit_valid_q <= credit_valid_d;
         credit_vc_q    <= credit_vc_d;
         overflow_q     <= overflow_d;
         protocol_q     <= protocol_d;
      end
   end

   assign not_empty_0  = (count_q[0] != '0);
   assign not_empty_1  = (count_q[1] != '0);
   assign not_empty_2  = (count_q[2] != '0);
   assign not_empty_3  = (count_q[3] != '0);
   assign full_0       = (count_q[0] == CNT_FULL);
   assign full_1       = (count_q[1] == CNT_FULL);
   assign full_2       = (count_q[2] == CNT_FULL);
   assign full_3       = (count_q[3] == CNT_FULL);
   assign out_valid    = out_valid_q;
   assign out_flit     = out_flit_q;
   assign out_vc       = out_vc_q;
   assign credit_valid = credit_valid_q;
   assign credit_vc    = credit_vc_q;
   assign overflow_err = overflow_q;
   assign protocol_err = protocol_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_input_buffer
//   Self-checking bench for vc_input_buffer: directed scenarios followed by
//   random traffic, compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_vc_input_buffer;

   localparam int FLIT_W = 34;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [1:0]        in_vc;
   logic [FLIT_W-1:0] in_flit;
   logic              rd_en;
   logic [1:0]        rd_vc;
   logic              not_empty_0, not_empty_1, not_empty_2, not_empty_3;
   logic              full_0, full_1, full_2, full_3;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic [1:0]        out_vc;
   logic              credit_valid;
   logic [1:0]        credit_vc;
   logic              overflow_err;
   logic              protocol_err;

   vc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .NUM_VC(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
      .rd_en(rd_en), .rd_vc(rd_vc),
      .not_empty_0(not_empty_0), .not_empty_1(not_empty_1),
      .not_empty_2(not_empty_2), .not_empty_3(not_empty_3),
      .full_0(full_0), .full_1(full_1), .full_2(full_2), .full_3(full_3),
      .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
      .credit_valid(credit_valid), .credit_vc(credit_vc),
      .overflow_err(overflow_err), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one queue per VC plus sticky flags and output registers
   logic [FLIT_W-1:0] mq [4][$];
   bit   [3:0]        m_active;
   bit                m_ovf, m_perr, m_ov;
   logic [FLIT_W-1:0] m_flit;
   logic [1:0]        m_ovc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < 4; v++) mq[v].delete();
      m_active = '0;
      m_ovf    = 1'b0;
      m_perr   = 1'b0;
      m_ov     = 1'b0;
      m_flit   = '0;
      m_ovc    = '0;
   endtask

   task automatic model_step(input bit iv, input bit [1:0] ivc, input logic [FLIT_W-1:0] fl,
                             input bit re, input bit [1:0] rvc);
      bit       pop, wok;
      bit [1:0] t;
      pop  = re && (mq[rvc].size() > 0);
      wok  = iv && ((mq[ivc].size() < DEPTH) || (pop && (rvc == ivc)));
      m_ov = pop;
      if (pop) begin
         m_flit = mq[rvc].pop_front();
         m_ovc  = rvc;
      end
      if (iv && !wok) m_ovf = 1'b1;
      if (wok) begin
         mq[ivc].push_back(fl);
         t = fl[FLIT_W-1 -: 2];
         // head-type flits (bit0 set) are legal only between packets
         if (m_active[ivc] ? t[0] : !t[0]) m_perr = 1'b1;
         if (t[0])      m_active[ivc] = !t[1];
         else if (t[1]) m_active[ivc] = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [3:0] ne_e, fu_e;
      for (int v = 0; v < 4; v++) begin
         ne_e[v] = (mq[v].size() != 0);
         fu_e[v] = (mq[v].size() == DEPTH);
      end
      check("not_empty", {60'd0, not_empty_3, not_empty_2, not_empty_1, not_empty_0}, {60'd0, ne_e});
      check("full", {60'd0, full_3, full_2, full_1, full_0}, {60'd0, fu_e});
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("out_flit", 64'(out_flit), 64'(m_flit));
      check("out_vc", 64'(out_vc), 64'(m_ovc));
      check("credit_valid", 64'(credit_valid), 64'(m_ov));
      if (m_ov) check("credit_vc", 64'(credit_vc), 64'(m_ovc));
      check("overflow_err", 64'(overflow_err), 64'(m_ovf));
      check("protocol_err", 64'(protocol_err), 64'(m_perr));
   endtask

   // Drives one cycle of stimulus (called at negedge), then checks after the edge
   task automatic cycle(input bit iv, input bit [1:0] ivc, input logic [FLIT_W-1:0] fl,
                        input bit re, input bit [1:0] rvc);
      in_valid = iv;
      in_vc    = ivc;
      in_flit  = fl;
      rd_en    = re;
      rd_vc    = rvc;
      model_step(iv, ivc, fl, re, rvc);
      @(negedge clk);
      check_outputs();
   endtask

   function automatic logic [FLIT_W-1:0] mk(input bit [1:0] t);
      logic [31:0] p;
      p  = $urandom();
      mk = {t, p};
   endfunction

   task automatic idle();
      cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
   endtask

   task automatic apply_reset();
      in_valid = 1'b0;
      rd_en    = 1'b0;
      rst      = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check("credit_vc_rst", 64'(credit_vc), 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_vc    = '0;
      in_flit  = '0;
      rd_en    = 1'b0;
      rd_vc    = '0;
      #2;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // head/body/tail into VC2, then drain back-to-back
      cycle(1, 2'd2, mk(2'b01), 0, 0);
      cycle(1, 2'd2, mk(2'b00), 0, 0);
      cycle(1, 2'd2, mk(2'b10), 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 2'd2);
      idle();
      idle();

      // fill VC0, overflow, then write to full VC0 with a same-VC pop
      cycle(1, 2'd0, mk(2'b01), 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 2'd0, mk(2'b00), 0, 0);
      cycle(1, 2'd0, mk(2'b00), 0, 0);
      idle();
      cycle(1, 2'd0, mk(2'b10), 1, 2'd0);
      idle();

      // pop on empty VC3 is ignored
      cycle(0, 0, '0, 1, 2'd3);
      idle();

      // framing violations on VC1, flits still stored
      cycle(1, 2'd1, mk(2'b00), 0, 0);
      cycle(1, 2'd1, mk(2'b01), 0, 0);
      cycle(1, 2'd1, mk(2'b01), 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 2'd1);
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 2'd0);
      idle();

      // load VC0 and VC3 then reset mid-stream; nothing survives
      cycle(1, 2'd0, mk(2'b01), 0, 0);
      cycle(1, 2'd3, mk(2'b01), 0, 0);
      cycle(1, 2'd0, mk(2'b00), 0, 0);
      cycle(1, 2'd3, mk(2'b00), 1, 2'd0);
      apply_reset();
      cycle(0, 0, '0, 1, 2'd0);
      cycle(0, 0, '0, 1, 2'd3);
      idle();

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         bit       iv, re;
         bit [1:0] ivc, rvc, t;
         iv  = ($urandom_range(0, 99) < 60);
         re  = ($urandom_range(0, 99) < 50);
         ivc = 2'($urandom_range(0, 3));
         rvc = 2'($urandom_range(0, 3));
         // mostly well-formed types so protocol_err is not set immediately
         t   = ($urandom_range(0, 99) < 90) ? (m_active[ivc] ? 2'($urandom_range(0, 1) << 1)
                                                              : 2'b01 | 2'($urandom_range(0, 1) << 1))
                                            : 2'($urandom_range(0, 3));
         cycle(iv, ivc, mk(t), re, rvc);
         if ($urandom_range(0, 999) == 0) apply_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Router input-port block. Receives link flits tagged with a VC id and writes them into four per-VC FIFOs.
- Exports one not-empty flag per VC; these drive the output round-robin arbiter's per-VC occupancy inputs.
- Pops the flit from the VC the arbiter selects and returns one credit per popped flit to the upstream router.
- Also checks packet framing (head/body/tail ordering) per VC.

Parameters:
FLIT_W, 34, flit width including 2-bit type field in bits [FLIT_W-1:FLIT_W-2] (00 body, 01 head, 10 tail, 11 head+tail)
DEPTH, 4, entries per VC FIFO; power of two, >=2
NUM_VC, 4, fixed at 4 (one flag port per VC); not to be overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  link flit present this cycle
in_vc  input  2  target VC of incoming flit
in_flit  input  FLIT_W  incoming flit
rd_en  input  1  pop request from arbiter side (arbiter 'selected')
rd_vc  input  2  VC to pop (arbiter buffer-select index)
not_empty_0..not_empty_3  output  1 each  VC n holds >=1 flit
full_0..full_3  output  1 each  VC n holds DEPTH flits
out_valid  output  1  out_flit/out_vc valid (registered)
out_flit  output  FLIT_W  popped flit
out_vc  output  2  VC the flit was popped from
credit_valid  output  1  one-cycle credit return pulse
credit_vc  output  2  VC of returned credit
overflow_err  output  1  sticky: write to full VC dropped
protocol_err  output  1  sticky: framing violation seen

Behaviour:
- Reset (rst low, async): all pointers and counts 0, all VC framing FSMs IDLE. All outputs 0: not_empty/full flags, out_valid, out_flit, out_vc, credit_valid, credit_vc, overflow_err, protocol_err. Reset mid-packet discards all stored flits; no credits are returned for them.
- Per-VC storage: wr_ptr, rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH; count of log2(DEPTH)+1 bits, range 0..DEPTH.
- not_empty_n = (count_n != 0) and full_n = (count_n == DEPTH). Both are combinational from registered counts.
- Write rule: when in_valid, the flit is written to VC in_vc at wr_ptr, wr_ptr advances and count increments, provided one of the following holds:
  - count < DEPTH, or
  - a pop on the same VC is accepted in the same cycle.
- Otherwise the flit is dropped: pointers and count are unchanged and overflow_err is set and held until reset.
- Read rule: rd_en with not_empty_rd_vc pops the entry at rd_ptr, advances rd_ptr and decrements count. rd_en on an empty VC is ignored: no output, no credit, no error.
- Simultaneous write and pop on the same VC: count unchanged, both pointers advance. Writes and pops on different VCs proceed independently.
- Output latency 1 cycle: the cycle after an accepted pop, out_valid=1, out_flit=popped entry, out_vc=rd_vc.
- In every cycle with no accepted pop in the previous cycle, out_valid=0 and out_flit/out_vc hold their last values.
- Credit: credit_valid pulses in the same cycle as out_valid, with credit_vc=out_vc. Exactly one credit per popped flit; none for dropped or ignored operations.
- Framing FSM per VC, states IDLE and ACTIVE, advanced only by accepted writes to that VC:
  - IDLE: head -> ACTIVE; head+tail -> stay IDLE; body or tail -> protocol_err, stay IDLE.
  - ACTIVE: body -> stay ACTIVE; tail -> IDLE; head or head+tail -> protocol_err, FSM takes the new flit's transition.
  - Flits that violate framing are still stored and forwarded.
  - Dropped (overflow) flits do not advance the FSM.
- protocol_err is sticky until reset.

Test Plan:
- Reset, then write head/body/tail (types 01,00,10) to VC2 on 3 consecutive cycles -> not_empty_2=1 after first edge, count 3, full_2=0; protocol_err=0.
- Pop VC2 three times back-to-back -> out_valid high 3 cycles starting 1 cycle after first rd_en, out_flit in write order, out_vc=2, credit_valid with credit_vc=2 each of those cycles; not_empty_2 falls after third pop.
- Fill VC0 with 4 flits (DEPTH=4), write a 5th with no pop -> full_0=1, 5th dropped, overflow_err=1 and stays 1; repeat with simultaneous pop on VC0 -> accepted, count stays 4, no new error.
- rd_en with rd_vc=3 while VC3 empty -> out_valid=0, credit_valid=0, no error flags change.
- Body flit to idle VC1, then head, then head again -> protocol_err=1 after first flit; flits still popped in order.
- Load VC0 and VC3 with 2 flits each, assert rst low mid-stream -> all flags, out_valid, credit_valid, errors 0 immediately; after release, pops return nothing.
